// File: rtl/seq_pkg.sv
// Shared constants, state encoding and DAC saturation helper for the sequence word packer.
package seq_pkg;

  localparam int SEQ_WORD_W    = 64;
  localparam int SLOT0_LSB     = 0;
  localparam int SLOT1_LSB     = 16;
  localparam int SLOT2_LSB     = 32;
  localparam int SLOT3_LSB     = 48;
  localparam int DAC_W         = 14;
  localparam int PDM_W         = 11;
  localparam int FLAG_LSB      = 60;
  localparam int DAC_RESET_BIT = 14;

  localparam logic signed [15:0] DAC_MAX = 16'sd8191;
  localparam logic signed [15:0] DAC_MIN = -16'sd8192;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic             clamped;
    logic [DAC_W-1:0] value;
  } sat_t;

  // Clamp a signed 16-bit DAC code into the signed 14-bit range and report clamping.
  function automatic sat_t sat14(input logic signed [15:0] v);
    sat_t r;
    if (v > DAC_MAX) begin
      r.value   = DAC_MAX[DAC_W-1:0];
      r.clamped = 1'b1;
    end else if (v < DAC_MIN) begin
      r.value   = DAC_MIN[DAC_W-1:0];
      r.clamped = 1'b1;
    end else begin
      r.value   = v[DAC_W-1:0];
      r.clamped = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_word_pack.sv
// Combinational saturate-and-pack of one sequence step into a 64-bit sequence word.
module seq_word_pack
  import seq_pkg::*;
(
  input  logic [1:0]            slot_mode,
  input  logic signed [15:0]    dac_value_0,
  input  logic signed [15:0]    dac_value_1,
  input  logic [PDM_W-1:0]      pdm_value_0,
  input  logic [PDM_W-1:0]      pdm_value_1,
  input  logic [PDM_W-1:0]      pdm_value_2,
  input  logic [PDM_W-1:0]      pdm_value_3,
  input  logic [3:0]            enable,
  input  logic                  dac_reset,
  output logic [SEQ_WORD_W-1:0] word,
  output logic                  clamped
);

  sat_t sat0;
  sat_t sat1;

  assign sat0 = sat14(dac_value_0);
  assign sat1 = sat14(dac_value_1);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    word    = '0;
    clamped = 1'b0;
    word[DAC_RESET_BIT] = dac_reset;
    if (slot_mode[0]) begin
      word[SLOT0_LSB +: DAC_W] = sat0.value;
      clamped = clamped | sat0.clamped;
    end else begin
      word[SLOT0_LSB +: PDM_W] = pdm_value_0;
    end
    // Slot 1 in DAC mode sign-extends the clamped value to fill the slot.
    if (slot_mode[1]) begin
      word[SLOT1_LSB +: DAC_W]     = sat1.value;
      word[SLOT1_LSB + DAC_W +: 2] = {2{sat1.value[DAC_W-1]}};
      clamped = clamped | sat1.clamped;
    end else begin
      word[SLOT1_LSB +: PDM_W] = pdm_value_1;
    end
    word[SLOT2_LSB +: PDM_W] = pdm_value_2;
    word[SLOT3_LSB +: PDM_W] = pdm_value_3;
    word[FLAG_LSB +: 4]      = enable;
  end

endmodule

// File: rtl/sequence_packer.sv
// Packs streamed sequence steps into 64-bit words and writes them to the sequence BRAM
// (one-shot or ring fill). Define SEQ_PACK_SAT_CNT_EN to add the sat_count output.
module sequence_packer
  import seq_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  cont,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       seq_len,
  input  logic [1:0]            slot_mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [15:0]    dac_value_0,
  input  logic signed [15:0]    dac_value_1,
  input  logic [PDM_W-1:0]      pdm_value_0,
  input  logic [PDM_W-1:0]      pdm_value_1,
  input  logic [PDM_W-1:0]      pdm_value_2,
  input  logic [PDM_W-1:0]      pdm_value_3,
  input  logic [3:0]            enable,
  input  logic                  dac_reset,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [SEQ_WORD_W-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  wrapped,
`ifdef SEQ_PACK_SAT_CNT_EN
  output logic [15:0]           sat_count,
`endif
  output logic [CNT_W-1:0]      words_written
);

  state_t                state;
  logic                  cont_q;
  logic [ADDR_W:0]       len_q;
  logic [1:0]            mode_q;
  logic [ADDR_W-1:0]     base_q;
  logic [ADDR_W:0]       index;
  logic [SEQ_WORD_W-1:0] packed_word;
  logic                  clamped;
  logic                  accept;
  logic                  last;

  assign in_ready = (state == S_RUN) & ~abort;
  assign accept   = in_valid & in_ready;
  assign last     = (index == len_q - (ADDR_W + 1)'(1));
  assign busy     = (state == S_RUN);
  assign done     = (state == S_DONE);

  seq_word_pack u_pack (
    .slot_mode   (mode_q),
    .dac_value_0 (dac_value_0),
    .dac_value_1 (dac_value_1),
    .pdm_value_0 (pdm_value_0),
    .pdm_value_1 (pdm_value_1),
    .pdm_value_2 (pdm_value_2),
    .pdm_value_3 (pdm_value_3),
    .enable      (enable),
    .dac_reset   (dac_reset),
    .word        (packed_word),
    .clamped     (clamped)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cont_q        <= 1'b0;
      len_q         <= '0;
      mode_q        <= '0;
      base_q        <= '0;
      index         <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      wrapped       <= 1'b0;
      words_written <= '0;
`ifdef SEQ_PACK_SAT_CNT_EN
      sat_count     <= '0;
`endif
    end else begin
      // The output register is independent of abort, so a write already accepted always lands.
      wr_en <= accept;
      if (accept) begin
        wr_addr <= base_q + index[ADDR_W-1:0];
        wr_data <= packed_word;
        if (words_written != '1) words_written <= words_written + CNT_W'(1);
`ifdef SEQ_PACK_SAT_CNT_EN
        if (clamped && sat_count != '1) sat_count <= sat_count + 16'd1;
`endif
      end

      if (abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              index         <= '0;
              words_written <= '0;
              wrapped       <= 1'b0;
              cont_q        <= cont;
              len_q         <= seq_len;
              mode_q        <= slot_mode;
              base_q        <= base_addr;
`ifdef SEQ_PACK_SAT_CNT_EN
              sat_count     <= '0;
`endif
              state         <= (seq_len == '0) ? S_DONE : S_RUN;
            end
          end
          S_RUN: begin
            if (accept) begin
              if (last && cont_q) begin
                index   <= '0;
                wrapped <= 1'b1;
              end else begin
                index <= index + (ADDR_W + 1)'(1);
                if (last) state <= S_DONE;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sequence_packer.sv
// Scoreboard bench for sequence_packer: directed steps push expected BRAM writes, a monitor checks them.
module tb_sequence_packer;

  localparam int ADDR_W = 14;
  localparam int CNT_W  = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                start, abort, cont;
  logic [ADDR_W-1:0]   base_addr;
  logic [ADDR_W:0]     seq_len;
  logic [1:0]          slot_mode;
  logic                in_valid, in_ready;
  logic signed [15:0]  dac_value_0, dac_value_1;
  logic [10:0]         pdm_value_0, pdm_value_1, pdm_value_2, pdm_value_3;
  logic [3:0]          enable;
  logic                dac_reset;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [63:0]         wr_data;
  logic                busy, done, wrapped;
  logic [CNT_W-1:0]    words_written;
`ifdef SEQ_PACK_SAT_CNT_EN
  logic [15:0]         sat_count;
`endif

  always #5 clk = ~clk;

  sequence_packer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .cont          (cont),
    .base_addr     (base_addr),
    .seq_len       (seq_len),
    .slot_mode     (slot_mode),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .dac_value_0   (dac_value_0),
    .dac_value_1   (dac_value_1),
    .pdm_value_0   (pdm_value_0),
    .pdm_value_1   (pdm_value_1),
    .pdm_value_2   (pdm_value_2),
    .pdm_value_3   (pdm_value_3),
    .enable        (enable),
    .dac_reset     (dac_reset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .wrapped       (wrapped),
`ifdef SEQ_PACK_SAT_CNT_EN
    .sat_count     (sat_count),
`endif
    .words_written (words_written)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [63:0]       data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every BRAM write must match the oldest outstanding expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {63'd0, wr_en}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", {50'd0, wr_addr}, {50'd0, mon_e.addr});
        check("wr_data", wr_data, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic start_run(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] len,
                           input logic c, input logic [1:0] m);
    @(negedge clk);
    base_addr = b;
    seq_len   = len;
    cont      = c;
    slot_mode = m;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic send(input logic signed [15:0] d0, input logic signed [15:0] d1,
                      input logic [10:0] p0, input logic [10:0] p1,
                      input logic [10:0] p2, input logic [10:0] p3,
                      input logic [3:0] en, input logic dr,
                      input logic [ADDR_W-1:0] ea, input logic [63:0] ed);
    int n = 0;
    @(negedge clk);
    dac_value_0 = d0;  dac_value_1 = d1;
    pdm_value_0 = p0;  pdm_value_1 = p1;
    pdm_value_2 = p2;  pdm_value_3 = p3;
    enable      = en;  dac_reset   = dr;
    in_valid    = 1'b1;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    else exp_q.push_back('{ea, ed});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; abort = 1'b0; cont = 1'b0;
    base_addr = '0; seq_len = '0; slot_mode = '0;
    in_valid = 1'b0;
    dac_value_0 = '0; dac_value_1 = '0;
    pdm_value_0 = '0; pdm_value_1 = '0; pdm_value_2 = '0; pdm_value_3 = '0;
    enable = '0; dac_reset = 1'b0;

    #22;
    check("reset_wr_en",    {63'd0, wr_en},    64'd0);
    check("reset_busy",     {63'd0, busy},     64'd0);
    check("reset_done",     {63'd0, done},     64'd0);
    check("reset_wrapped",  {63'd0, wrapped},  64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd0);
    check("reset_words",    {32'd0, words_written}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // One-shot DAC fill, three identical steps.
    start_run(14'h100, 3, 1'b0, 2'b11);
    for (int i = 0; i < 3; i++)
      send(16'sd100, 16'sd0, 11'h0, 11'h0, 11'h0, 11'h0, 4'hF, 1'b1,
           14'h100 + 14'(i), 64'hF000_0000_0000_4064);
    @(negedge clk);
    check("fill1_done",     {63'd0, done},     64'd1);
    check("fill1_busy",     {63'd0, busy},     64'd0);
    check("fill1_in_ready", {63'd0, in_ready}, 64'd0);
    check("fill1_words",    {32'd0, words_written}, 64'd3);

    // DAC sign extension and clamp boundaries.
    start_run(14'h200, 4, 1'b0, 2'b11);
    send(16'sd0, -16'sd1, 11'h0, 11'h0, 11'h123, 11'h0, 4'h0, 1'b0,
         14'h200, 64'h0000_0123_FFFF_0000);
    send(16'sd20000, 16'sd0, 11'h0, 11'h0, 11'h0, 11'h0, 4'h0, 1'b0,
         14'h201, 64'h0000_0000_0000_1FFF);
    send(-16'sd20000, 16'sd0, 11'h0, 11'h0, 11'h0, 11'h0, 4'h0, 1'b0,
         14'h202, 64'h0000_0000_0000_2000);
    send(16'sd8191, -16'sd8192, 11'h0, 11'h0, 11'h0, 11'h0, 4'h0, 1'b0,
         14'h203, 64'h0000_0000_E000_1FFF);
    @(negedge clk);
    check("fill2_done",  {63'd0, done}, 64'd1);
    check("fill2_words", {32'd0, words_written}, 64'd4);
`ifdef SEQ_PACK_SAT_CNT_EN
    check("fill2_sat_count", {48'd0, sat_count}, 64'd2);
`endif

    // All-PDM slots; DAC inputs must be ignored.
    start_run(14'h000, 1, 1'b0, 2'b00);
    send(16'sd20000, -16'sd20000, 11'h7FF, 11'h2AA, 11'h0, 11'h555, 4'h0, 1'b0,
         14'h000, 64'h0555_0000_02AA_07FF);
    @(negedge clk);
    check("pdm_done", {63'd0, done}, 64'd1);
`ifdef SEQ_PACK_SAT_CNT_EN
    check("pdm_sat_count", {48'd0, sat_count}, 64'd0);
`endif

    // Mixed: slot 0 PDM with dac_reset, slot 1 DAC clamped negative.
    start_run(14'h020, 1, 1'b0, 2'b10);
    send(16'sd20000, -16'sd20000, 11'h3FF, 11'h0, 11'h0, 11'h0, 4'h5, 1'b1,
         14'h020, 64'h5000_0000_E000_43FF);
    @(negedge clk);
`ifdef SEQ_PACK_SAT_CNT_EN
    check("mixed_sat_count", {48'd0, sat_count}, 64'd1);
`endif
    check("mixed_words", {32'd0, words_written}, 64'd1);

    // Ring fill across the top of the address space.
    start_run(14'h3FFF, 2, 1'b1, 2'b11);
    for (int i = 0; i < 5; i++)
      send(16'(i), 16'sd0, 11'h0, 11'h0, 11'h0, 11'h0, 4'h0, 1'b0,
           (i % 2 == 0) ? 14'h3FFF : 14'h0000, 64'(i));
    @(negedge clk);
    check("ring_wrapped", {63'd0, wrapped}, 64'd1);
    check("ring_done",    {63'd0, done},    64'd0);
    check("ring_busy",    {63'd0, busy},    64'd1);
    check("ring_words",   {32'd0, words_written}, 64'd5);

    // Abort right after an accept: the pending write lands, nothing new is taken.
    send(16'sd7, 16'sd0, 11'h0, 11'h0, 11'h0, 11'h0, 4'h0, 1'b0, 14'h0000, 64'd7);
    dac_value_0 = 16'sd9;
    in_valid = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    check("abort_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);

    // start and abort together: abort wins.
    seq_len = 2; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", {63'd0, busy}, 64'd0);
    check("start_abort_done", {63'd0, done}, 64'd0);

    // Zero-length start goes straight to DONE and clears the counters.
    start_run(14'h005, 0, 1'b0, 2'b11);
    check("zero_len_done",    {63'd0, done},    64'd1);
    check("zero_len_busy",    {63'd0, busy},    64'd0);
    check("zero_len_words",   {32'd0, words_written}, 64'd0);
    check("zero_len_wrapped", {63'd0, wrapped}, 64'd0);

    // Asynchronous reset while a write is on the bus.
    start_run(14'h010, 4, 1'b0, 2'b11);
    send(16'sd5, 16'sd0, 11'h0, 11'h0, 11'h0, 11'h0, 4'h0, 1'b0, 14'h010, 64'd5);
    in_valid = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("rst_wr_en",   {63'd0, wr_en},   64'd0);
    check("rst_busy",    {63'd0, busy},    64'd0);
    check("rst_wr_addr", {50'd0, wr_addr}, 64'd0);
    check("rst_wr_data", wr_data,          64'd0);
    check("rst_words",   {32'd0, words_written}, 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_busy", {63'd0, busy}, 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
